// File: rtl/ddr_sched_pkg.sv
// Shared state/grant types and default sizing for the DDR burst scheduler.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_GAP  = 3'd4
  } sched_state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  localparam int DEF_ADDR_W     = 25;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_BURST_LEN  = 256;
  localparam int DEF_FIFO_DEPTH = 512;
  localparam int DEF_REGION_MAX = 1000000;

endpackage

// File: rtl/ddr_addr_gen.sv
// Burst address generator: advances by one burst per step, wraps to BASE at MAX
// with a one-cycle wrap pulse, and defers loads that arrive mid-burst.
module ddr_addr_gen
  import ddr_sched_pkg::*;
#(
  parameter int BASE      = 0,
  parameter int MAX       = DEF_REGION_MAX,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap_pulse
);

  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   STEP_C = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   MAX_C  = (ADDR_W + 1)'(MAX);

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   next_s;
  logic              pend_r;
  logic              wrap_r;

  // One extra bit so the region-end compare cannot be fooled by overflow
  assign next_s = {1'b0, addr_r} + STEP_C;

  // Address register, pending-load flag and wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= BASE_C;
      pend_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (step) begin
        pend_r <= 1'b0;
        if (load || pend_r) begin
          addr_r <= BASE_C;
        end else if (next_s >= MAX_C) begin
          addr_r <= BASE_C;
          wrap_r <= 1'b1;
        end else begin
          addr_r <= next_s[ADDR_W-1:0];
        end
      end else if (load) begin
        // Address must not move under an active request; apply at finish
        if (busy) begin
          pend_r <= 1'b1;
        end else begin
          addr_r <= BASE_C;
          pend_r <= 1'b0;
        end
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign addr       = addr_r;
  assign wrap_pulse = wrap_r;

endmodule

// File: rtl/ddr_burst_sched.sv
// DDR burst scheduler: eligibility, round-robin arbitration between write and
// read bursts, and the request handshake with the DDR controller.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WR_BASE    = 0,
  parameter int WR_MAX     = DEF_REGION_MAX,
  parameter int RD_BASE    = 0,
  parameter int RD_MAX     = DEF_REGION_MAX
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              ddr_init_done,
  input  logic [CNT_W-1:0]  wrf_usedw,
  input  logic [CNT_W-1:0]  rdf_usedw,
  input  logic              rd_enable,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              wr_burst_req,
  output logic [ADDR_W-1:0] wr_burst_addr,
  input  logic              wr_burst_finish,
  output logic              rd_burst_req,
  output logic [ADDR_W-1:0] rd_burst_addr,
  input  logic              rd_burst_finish,
  output logic              frame_write_done,
  output logic              frame_read_done
);

  localparam logic [CNT_W:0] WR_THRESH_C = (CNT_W + 1)'(BURST_LEN);
  localparam logic [CNT_W:0] RD_THRESH_C = (CNT_W + 1)'(FIFO_DEPTH - BURST_LEN);

  sched_state_e state_r, state_nx_s;
  grant_e       last_grant_r, last_grant_nx_s;
  logic         wr_req_r, rd_req_r;
  logic         wr_elig_s, rd_elig_s;
  logic         wr_busy_s, rd_busy_s;
  logic         wr_step_s, rd_step_s;

  assign wr_elig_s = ({1'b0, wrf_usedw} >= WR_THRESH_C);
  assign rd_elig_s = rd_enable && ({1'b0, rdf_usedw} <= RD_THRESH_C);
  assign wr_busy_s = (state_r == ST_WR);
  assign rd_busy_s = (state_r == ST_RD);
  assign wr_step_s = wr_busy_s && wr_burst_finish;
  assign rd_step_s = rd_busy_s && rd_burst_finish;

  // Next-state and arbitration; a tie goes to the side not granted last
  always_comb begin
    state_nx_s      = state_r;
    last_grant_nx_s = last_grant_r;
    case (state_r)
      ST_INIT: begin
        if (ddr_init_done) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (!ddr_init_done) begin
          state_nx_s = ST_INIT;
        end else if (wr_elig_s && (!rd_elig_s || (last_grant_r == GNT_RD))) begin
          state_nx_s      = ST_WR;
          last_grant_nx_s = GNT_WR;
        end else if (rd_elig_s) begin
          state_nx_s      = ST_RD;
          last_grant_nx_s = GNT_RD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if (wr_burst_finish) begin
          state_nx_s = ST_GAP;
        end else begin
          state_nx_s = ST_WR;
        end
      end
      ST_RD: begin
        if (rd_burst_finish) begin
          state_nx_s = ST_GAP;
        end else begin
          state_nx_s = ST_RD;
        end
      end
      ST_GAP:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_INIT;
    endcase
  end

  // State, last grant and registered requests
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      last_grant_r <= GNT_RD;
      wr_req_r     <= 1'b0;
      rd_req_r     <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      last_grant_r <= last_grant_nx_s;
      wr_req_r     <= (state_nx_s == ST_WR);
      rd_req_r     <= (state_nx_s == ST_RD);
    end
  end

  ddr_addr_gen #(
    .BASE(WR_BASE), .MAX(WR_MAX), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)
  ) u_wr_addr (
    .clk(clk_ref), .rst_n(rst_n), .step(wr_step_s), .load(wr_load),
    .busy(wr_busy_s), .addr(wr_burst_addr), .wrap_pulse(frame_write_done)
  );

  ddr_addr_gen #(
    .BASE(RD_BASE), .MAX(RD_MAX), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)
  ) u_rd_addr (
    .clk(clk_ref), .rst_n(rst_n), .step(rd_step_s), .load(rd_load),
    .busy(rd_busy_s), .addr(rd_burst_addr), .wrap_pulse(frame_read_done)
  );

  assign wr_burst_req = wr_req_r;
  assign rd_burst_req = rd_req_r;

endmodule

// File: doc/ddr_burst_sched.md
# ddr_burst_sched

Burst scheduler between the write/read FIFO pair and the DDR burst controller. It decides when a write burst (FIFO→DDR) or a read burst (DDR→FIFO) is issued, and arbitrates round-robin when both are eligible. It generates and wraps the write and read burst addresses, and pulses frame-done when a region wraps. It sits in the `phy_clk` domain between the dual-clock FIFO wrapper and `ddr_ctrl`.

## Interface
Parameters:
- `ADDR_W`, 25, DDR word-address width
- `CNT_W`, 10, FIFO used-word count width
- `BURST_LEN`, 256, words per burst, also the address increment
- `FIFO_DEPTH`, 512, read FIFO depth in words
- `WR_BASE` / `WR_MAX`, 0 / 1000000, write region start and exclusive end
- `RD_BASE` / `RD_MAX`, 0 / 1000000, read region start and exclusive end

Ports:
- `clk_ref`  in  1  single clock (`phy_clk` from `ddr_ctrl`)
- `rst_n`  in  1  asynchronous, active-low reset
- `ddr_init_done`  in  1  DDR calibrated
- `wrf_usedw`  in  CNT_W  words waiting in write FIFO (`clk_ref`-side count)
- `rdf_usedw`  in  CNT_W  words held in read FIFO (`clk_ref`-side count)
- `rd_enable`  in  1  read path enabled (data_valid)
- `wr_load` / `rd_load`  in  1  single-cycle pulse that resets the address to its base
- `wr_burst_req`  out  1  write burst request to `ddr_ctrl`
- `wr_burst_addr`  out  ADDR_W  write burst start address
- `wr_burst_finish`  in  1  single-cycle pulse, write burst done
- `rd_burst_req`  out  1  read burst request
- `rd_burst_addr`  out  ADDR_W  read burst start address
- `rd_burst_finish`  in  1  single-cycle pulse, read burst done
- `frame_write_done` / `frame_read_done`  out  1  single-cycle pulse on region wrap

## Operation
- **States:** INIT, IDLE, WR, RD, GAP.
- **Reset values:** state INIT; both req 0; addresses WR_BASE / RD_BASE; frame pulses 0; last_grant = RD, so the first tie goes to write.
- **INIT:** go to IDLE when `ddr_init_done` = 1.
- **Eligibility:**
  - Write is eligible when `wrf_usedw >= BURST_LEN`.
  - Read is eligible when `rd_enable` = 1 and `rdf_usedw <= FIFO_DEPTH - BURST_LEN`.
- **IDLE:**
  - If `ddr_init_done` = 0, go to INIT.
  - If only one side is eligible, grant it.
  - If both are eligible, grant the side opposite `last_grant`.
  - On grant, go to WR or RD, assert that side's req, and record `last_grant`.
- **WR / RD:** req held at 1 until the matching finish pulse is sampled. Then:
  - req clears;
  - that side's address advances;
  - state goes to GAP.
  - `ddr_init_done` falling mid-burst is ignored until finish.
- **GAP:** one cycle to let the FIFO counts settle, then IDLE.
- **Address advance:**
  - next = addr + BURST_LEN, computed at ADDR_W+1 bits.
  - If next >= MAX, the address becomes BASE and the frame_done pulse fires the following cycle.
  - Otherwise the address becomes next.
- **Load:**
  - `*_load` in IDLE, INIT or GAP sets the address to BASE immediately.
  - During an active burst on the same side, the load is latched as pending and applied at finish instead of the advance.
  - Load coinciding with finish: load wins and frame_done is not pulsed.
- A finish pulse for the side that is not active is ignored.
- The address outputs are stable while the corresponding req is high.

## Timing
- IDLE with a side eligible in cycle N → req high in N+1.
- Finish high in cycle N → req low and new address in N+1 (GAP) → IDLE in N+2 → earliest next req in N+3.
- frame_done is high for exactly the cycle after the wrapping finish.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package `ddr_sched_pkg`: state enum (INIT, IDLE, WR, RD, GAP), grant enum (GNT_WR, GNT_RD), default width constants.
- Sub-module `ddr_addr_gen`, instantiated twice (write, read):
  - params BASE, MAX, BURST_LEN, ADDR_W;
  - inputs `step`, `load`, `busy`;
  - outputs `addr`, `wrap_pulse`;
  - owns the pending-load flag.
- Top-level file holds the FSM and arbitration only.

## Test plan
- Reset held, `ddr_init_done` = 0, `wrf_usedw` = 300 → no req. Release init → `wr_burst_req` = 1 two cycles later, `wr_burst_addr` = 0.
- `wrf_usedw` = 300, `rdf_usedw` = 0, `rd_enable` = 1, finish 20 cycles after each req → grants alternate WR, RD, WR. Addresses after 3 grants: write 512, read 256.
- Write address at 999936 (next = 1000192 ≥ 1000000), finish pulse → address 0, `frame_write_done` one cycle high, exactly once.
- `wr_load` mid write burst at address 2048 → address stays 2048 until finish, then 0 (not 2304); no frame pulse.
- `rdf_usedw` = 300 (> 256) or `rd_enable` = 0 with no write work → `rd_burst_req` never asserted. Drop `rdf_usedw` to 256 → req asserted.
- `ddr_init_done` drops during an RD burst → req stays high until `rd_burst_finish`, then GAP → IDLE → INIT; no new req until init returns.
